fifo_ctrl_fsm: RTL and testbench

- Main control state machine for the transmit-path FIFO bank: configures FIFO thresholds, sequences FIFO clear/enable, and monitors FIFO status.
- Sits above the N per-lane FIFOs.
- Drives their shared `init` and `Umbral` inputs.
- Reports IDLE / ACTIVE / ERROR status to the link layer.

---
 rtl/fifo_ctrl_fsm.sv | 111 +++++++++++
 tb/tb_fifo_ctrl_fsm.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_fsm.sv
// fifo_ctrl_fsm: main control FSM for the transmit-path FIFO bank.
// Loads clamped FIFO thresholds while in INIT, enables the FIFOs outside
// RESET/INIT, tracks empty/active status and latches per-FIFO error sources.
// Optional macro: FIFO_CTRL_ERR_RECOVER_EN lets init=1 leave ERROR for INIT
// and clears error_src on that edge; without it ERROR is terminal until reset.
module fifo_ctrl_fsm #(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned UMBRAL_W  = 4,
  parameter int unsigned SIZE_FIFO = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [UMBRAL_W-1:0]  umbral_lo_in,
  input  logic [UMBRAL_W-1:0]  umbral_hi_in,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [NUM_FIFOS-1:0] fifo_error,
  output logic                 fifo_init,
  output logic [UMBRAL_W-1:0]  umbral_lo_out,
  output logic [UMBRAL_W-1:0]  umbral_hi_out,
  output logic [2:0]           state,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic [NUM_FIFOS-1:0] error_src
);

  typedef enum logic [2:0] {
    StReset  = 3'b000,
    StInit   = 3'b001,
    StIdle   = 3'b010,
    StActive = 3'b011,
    StError  = 3'b100
  } state_e;

  // Threshold ceiling; SIZE_FIFO is required to fit in UMBRAL_W bits.
  localparam logic [UMBRAL_W-1:0] SizeMax = UMBRAL_W'(SIZE_FIFO);

  state_e                state_q, state_d;
  logic [UMBRAL_W-1:0]   umbral_lo_q, umbral_lo_d;
  logic [UMBRAL_W-1:0]   umbral_hi_q, umbral_hi_d;
  logic [NUM_FIFOS-1:0]  error_src_q, error_src_d;

  // Next-state, threshold loading and error-source accumulation.
  always_comb begin
    state_d     = state_q;
    umbral_lo_d = umbral_lo_q;
    umbral_hi_d = umbral_hi_q;
    error_src_d = error_src_q;
    case (state_q)
      StReset: state_d = StInit;
      StInit: begin
        // Errors are ignored here: the FIFOs are held cleared.
        umbral_lo_d = (umbral_lo_in > SizeMax) ? SizeMax : umbral_lo_in;
        umbral_hi_d = (umbral_hi_in > SizeMax) ? SizeMax : umbral_hi_in;
        if (!init) state_d = StIdle;
      end
      StIdle, StActive: begin
        if (|fifo_error) begin
          state_d     = StError;
          error_src_d = error_src_q | fifo_error;
        end else if (init) begin
          state_d = StInit;
        end else if (state_q == StIdle) begin
          if (!(&fifo_empty)) state_d = StActive;
        end else begin
          if (&fifo_empty) state_d = StIdle;
        end
      end
      StError: begin
        error_src_d = error_src_q | fifo_error;
`ifdef FIFO_CTRL_ERR_RECOVER_EN
        if (init) begin
          state_d     = StInit;
          error_src_d = '0;
        end
`endif
      end
      default: state_d = StReset;
    endcase
  end

  // State and data registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StReset;
      umbral_lo_q <= '0;
      umbral_hi_q <= '0;
      error_src_q <= '0;
    end else begin
      state_q     <= state_d;
      umbral_lo_q <= umbral_lo_d;
      umbral_hi_q <= umbral_hi_d;
      error_src_q <= error_src_d;
    end
  end

  // Status outputs decoded purely from the state register.
  always_comb begin
    state      = state_q;
    idle_out   = (state_q == StIdle);
    active_out = (state_q == StActive);
    error_out  = (state_q == StError);
    fifo_init  = (state_q == StIdle) || (state_q == StActive) || (state_q == StError);
  end

  assign umbral_lo_out = umbral_lo_q;
  assign umbral_hi_out = umbral_hi_q;
  assign error_src     = error_src_q;

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Testbench for fifo_ctrl_fsm: directed vector table, hand-written corner
// sequences (error recovery, mid-cycle reset) and a randomized run checked
// against a behavioural model.
module tb_fifo_ctrl_fsm;

  localparam int SIZE = 4;
  localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

  logic       clk, reset_L, init;
  logic [3:0] lo_in, hi_in, empty, err;
  logic       fifo_init, idle_out, active_out, error_out;
  logic [3:0] lo_out, hi_out, error_src;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  int m_state, m_lo, m_hi, m_src;

  fifo_ctrl_fsm #(.NUM_FIFOS(4), .UMBRAL_W(4), .SIZE_FIFO(4)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .umbral_lo_in (lo_in),
    .umbral_hi_in (hi_in),
    .fifo_empty   (empty),
    .fifo_error   (err),
    .fifo_init    (fifo_init),
    .umbral_lo_out(lo_out),
    .umbral_hi_out(hi_out),
    .state        (state),
    .idle_out     (idle_out),
    .active_out   (active_out),
    .error_out    (error_out),
    .error_src    (error_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare every output against an expected state / threshold / source triple.
  task automatic chk_all(input string name, input int st, input int lo, input int hi,
                         input int src);
    chk({name, ".state"}, int'(state), st);
    chk({name, ".idle"}, int'(idle_out), int'(st == S_IDLE));
    chk({name, ".active"}, int'(active_out), int'(st == S_ACTIVE));
    chk({name, ".error"}, int'(error_out), int'(st == S_ERROR));
    chk({name, ".fifo_init"}, int'(fifo_init), int'(st >= S_IDLE));
    chk({name, ".lo"}, int'(lo_out), lo);
    chk({name, ".hi"}, int'(hi_out), hi);
    chk({name, ".src"}, int'(error_src), src);
  endtask

  function automatic int clampf(input int v);
    return (v > SIZE) ? SIZE : v;
  endfunction

  task automatic model_reset();
    m_state = S_RESET; m_lo = 0; m_hi = 0; m_src = 0;
  endtask

  // One clock edge of the reference behaviour, from current inputs.
  task automatic model_step();
    int e = int'(err);
    if (m_state == S_RESET) begin
      m_state = S_INIT;
    end else if (m_state == S_INIT) begin
      m_lo = clampf(int'(lo_in));
      m_hi = clampf(int'(hi_in));
      if (!init) m_state = S_IDLE;
    end else if (m_state == S_IDLE || m_state == S_ACTIVE) begin
      if (e != 0) begin
        m_src = m_src | e;
        m_state = S_ERROR;
      end else if (init) m_state = S_INIT;
      else if (m_state == S_IDLE && empty != 4'hF) m_state = S_ACTIVE;
      else if (m_state == S_ACTIVE && empty == 4'hF) m_state = S_IDLE;
    end else begin
      m_src = m_src | e;
`ifdef FIFO_CTRL_ERR_RECOVER_EN
      if (init) begin
        m_state = S_INIT;
        m_src = 0;
      end
`endif
    end
  endtask

  typedef struct {
    logic       init;
    logic [3:0] lo, hi, empty, err;
    int         st, elo, ehi, esrc;
  } vec_t;

  function automatic vec_t mk(input logic i, input logic [3:0] l, input logic [3:0] h,
                              input logic [3:0] e, input logic [3:0] r, input int st,
                              input int elo, input int ehi, input int esrc);
    vec_t v;
    v.init = i; v.lo = l; v.hi = h; v.empty = e; v.err = r;
    v.st = st; v.elo = elo; v.ehi = ehi; v.esrc = esrc;
    return v;
  endfunction

  task automatic do_reset();
    reset_L = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    vec_t vecs[12];
    vecs[0]  = mk(1, 4'd1, 4'd3, 4'hF, 4'h0, S_INIT,   0, 0, 0);
    vecs[1]  = mk(1, 4'd1, 4'd3, 4'hF, 4'h0, S_INIT,   1, 3, 0);
    vecs[2]  = mk(0, 4'd1, 4'd3, 4'hF, 4'h0, S_IDLE,   1, 3, 0);
    vecs[3]  = mk(1, 4'd7, 4'd9, 4'hF, 4'h0, S_INIT,   1, 3, 0);
    vecs[4]  = mk(1, 4'd7, 4'd9, 4'hF, 4'h0, S_INIT,   4, 4, 0);
    vecs[5]  = mk(0, 4'd7, 4'd9, 4'hF, 4'h0, S_IDLE,   4, 4, 0);
    vecs[6]  = mk(0, 4'd2, 4'd2, 4'hF, 4'h0, S_IDLE,   4, 4, 0);
    vecs[7]  = mk(0, 4'd2, 4'd2, 4'hB, 4'h0, S_ACTIVE, 4, 4, 0);
    vecs[8]  = mk(0, 4'd2, 4'd2, 4'hF, 4'h0, S_IDLE,   4, 4, 0);
    vecs[9]  = mk(0, 4'd2, 4'd2, 4'hB, 4'h0, S_ACTIVE, 4, 4, 0);
    vecs[10] = mk(1, 4'd2, 4'd2, 4'hB, 4'h4, S_ERROR,  4, 4, 4);
    vecs[11] = mk(0, 4'd2, 4'd2, 4'hB, 4'h1, S_ERROR,  4, 4, 5);

    reset_L = 1'b0; init = 1'b1; lo_in = 4'd1; hi_in = 4'd3; empty = 4'hF; err = 4'h0;
    #1;
    chk_all("reset", S_RESET, 0, 0, 0);
    @(negedge clk);
    reset_L = 1'b1;

    // Directed table: one vector per clock edge.
    for (int i = 0; i < 12; i++) begin
      init = vecs[i].init; lo_in = vecs[i].lo; hi_in = vecs[i].hi;
      empty = vecs[i].empty; err = vecs[i].err;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].elo, vecs[i].ehi, vecs[i].esrc);
    end

    // ERROR with init=1: recovery only when the feature is built in.
    init = 1'b1; err = 4'h0;
    @(posedge clk);
    @(negedge clk);
`ifdef FIFO_CTRL_ERR_RECOVER_EN
    chk_all("err_init", S_INIT, 4, 4, 0);
`else
    chk_all("err_init", S_ERROR, 4, 4, 5);
    @(posedge clk);
    @(negedge clk);
    chk_all("err_init2", S_ERROR, 4, 4, 5);
`endif

    // Mid-cycle asynchronous reset while ACTIVE.
    init = 1'b0; lo_in = 4'd2; hi_in = 4'd3; empty = 4'hF; err = 4'h0;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    empty = 4'h0;
    @(negedge clk);
    chk_all("pre_rst", S_ACTIVE, 2, 3, 0);
    @(posedge clk);
    #3;
    reset_L = 1'b0;
    #1;
    chk_all("mid_rst", S_RESET, 0, 0, 0);
    @(negedge clk);
    reset_L = 1'b1;

    // Randomized run against the behavioural model.
    model_reset();
    for (int i = 0; i < 600; i++) begin
      init  = ($urandom_range(7) == 0);
      lo_in = 4'($urandom_range(15));
      hi_in = 4'($urandom_range(15));
      empty = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom_range(15));
      err   = ($urandom_range(24) == 0) ? 4'($urandom_range(15)) : 4'h0;
      if ($urandom_range(39) == 0) begin
        reset_L = 1'b0;
        model_reset();
        #1;
        chk_all("rnd_rst", m_state, m_lo, m_hi, m_src);
        @(negedge clk);
        reset_L = 1'b1;
      end else begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk_all($sformatf("rnd%0d", i), m_state, m_lo, m_hi, m_src);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
